// File: rtl/chip8_regmem_sequencer.sv
// Chip-8 Fx55 / Fx65 / Fx33 sequencer that moves bytes between the V register file and main memory.
// Define CHIP8_I_INCREMENT_EN to add the i_wr / i_next outputs (COSMAC-style I update after store/load).
module chip8_regmem_sequencer #(
   parameter int ADDR_W = 12,
   parameter int DATA_W = 8
) (
   input  logic              cpu_clk,
   input  logic              reset,
   input  logic              start,
   input  logic [1:0]        op,
   input  logic [3:0]        x,
   input  logic [ADDR_W-1:0] i_addr,
   output logic              busy,
   output logic              done,
   output logic [3:0]        reg_addr,
   output logic [DATA_W-1:0] reg_writedata,
   output logic              reg_WE,
   input  logic [DATA_W-1:0] reg_readdata,
   output logic [ADDR_W-1:0] mem_addr,
   output logic [DATA_W-1:0] mem_writedata,
   output logic              mem_WE,
   input  logic [DATA_W-1:0] mem_readdata
`ifdef CHIP8_I_INCREMENT_EN
   ,
   output logic              i_wr,
   output logic [ADDR_W-1:0] i_next
`endif
);

   typedef enum logic [3:0] {
      IDLE, ST_RD, ST_WR, LD_RD, LD_WR,
      BC_RD, BC_CALC, BC_WH, BC_WT, BC_WO, DONE
   } state_e;

   state_e              state_q, state_d;
   logic [3:0]          k_q, k_d;
   logic [3:0]          x_q, x_d;
   logic [ADDR_W-1:0]   i_q, i_d;
   logic [DATA_W-1:0]   v_q, v_d;
   logic [ADDR_W-1:0]   addr_k;
   logic [DATA_W-1:0]   rem, hund, tens, ones;
`ifdef CHIP8_I_INCREMENT_EN
   logic [1:0]          op_q, op_d;
`endif

   // NOTE: state flops use non-blocking assignments so every flop samples pre-edge values.
   always_ff @(posedge cpu_clk) begin
      if (reset) begin
         state_q <= IDLE;
         k_q     <= '0;
         x_q     <= '0;
         i_q     <= '0;
         v_q     <= '0;
`ifdef CHIP8_I_INCREMENT_EN
         op_q    <= '0;
`endif
      end else begin
         state_q <= state_d;
         k_q     <= k_d;
         x_q     <= x_d;
         i_q     <= i_d;
         v_q     <= v_d;
`ifdef CHIP8_I_INCREMENT_EN
         op_q    <= op_d;
`endif
      end
   end

   // NOTE: every comb output gets a default first so no path leaves it unassigned (no latches).
   always_comb begin
      state_d = state_q;
      k_d     = k_q;
      x_d     = x_q;
      i_d     = i_q;
      v_d     = v_q;
`ifdef CHIP8_I_INCREMENT_EN
      op_d    = op_q;
`endif
      unique case (state_q)
         IDLE: if (start) begin
            k_d = '0;
            x_d = x;
            i_d = i_addr;
`ifdef CHIP8_I_INCREMENT_EN
            op_d = op;
`endif
            unique case (op)
               2'b00:   state_d = ST_RD;
               2'b01:   state_d = LD_RD;
               2'b10:   state_d = BC_RD;
               default: state_d = DONE;
            endcase
         end
         ST_RD:   state_d = ST_WR;
         ST_WR:   if (k_q == x_q) state_d = DONE; else begin k_d = k_q + 4'd1; state_d = ST_RD; end
         LD_RD:   state_d = LD_WR;
         LD_WR:   if (k_q == x_q) state_d = DONE; else begin k_d = k_q + 4'd1; state_d = LD_RD; end
         BC_RD:   state_d = BC_CALC;
         BC_CALC: begin v_d = reg_readdata; state_d = BC_WH; end
         BC_WH:   state_d = BC_WT;
         BC_WT:   state_d = BC_WO;
         BC_WO:   state_d = DONE;
         DONE:    state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   // Restoring compare-subtract BCD of the latched byte: hundreds <= 2, tens built from 80/40/20/10.
   // NOTE: blocking assignments here chain each subtraction into the next compare within one cycle.
   always_comb begin
      rem  = v_q;
      hund = '0;
      tens = '0;
      if (rem >= DATA_W'(200)) begin
         hund = DATA_W'(2);
         rem  = rem - DATA_W'(200);
      end else if (rem >= DATA_W'(100)) begin
         hund = DATA_W'(1);
         rem  = rem - DATA_W'(100);
      end
      for (int b = 3; b >= 0; b--) begin
         if (rem >= DATA_W'(10 << b)) begin
            tens = tens | DATA_W'(1 << b);
            rem  = rem - DATA_W'(10 << b);
         end
      end
      ones = rem;
   end

   assign addr_k = i_q + ADDR_W'(k_q);

   always_comb begin
      busy          = (state_q != IDLE);
      done          = 1'b0;
      reg_addr      = '0;
      reg_writedata = '0;
      reg_WE        = 1'b0;
      mem_addr      = '0;
      mem_writedata = '0;
      mem_WE        = 1'b0;
      unique case (state_q)
         ST_RD: reg_addr = k_q;
         ST_WR: begin mem_addr = addr_k; mem_writedata = reg_readdata; mem_WE = 1'b1; end
         LD_RD: mem_addr = addr_k;
         LD_WR: begin reg_addr = k_q; reg_writedata = mem_readdata; reg_WE = 1'b1; end
         BC_RD: reg_addr = x_q;
         BC_WH: begin mem_addr = i_q;                   mem_writedata = hund; mem_WE = 1'b1; end
         BC_WT: begin mem_addr = i_q + ADDR_W'(1);      mem_writedata = tens; mem_WE = 1'b1; end
         BC_WO: begin mem_addr = i_q + ADDR_W'(2);      mem_writedata = ones; mem_WE = 1'b1; end
         DONE:  done = 1'b1;
         default: ;
      endcase
   end

`ifdef CHIP8_I_INCREMENT_EN
   always_comb begin
      i_wr   = (state_q == DONE) && (op_q == 2'b00 || op_q == 2'b01);
      i_next = i_wr ? (i_q + ADDR_W'(x_q) + ADDR_W'(1)) : '0;
   end
`endif

endmodule

// File: doc/chip8_regmem_sequencer.md
Name: chip8_regmem_sequencer

Overview:
Multi-cycle controller that moves bytes between the Chip-8 V register file and main memory for Fx55 (store V0..Vx), Fx65 (load V0..Vx) and Fx33 (BCD of Vx). It sits beside the CPU decode logic, which issues a single-cycle start and stalls on busy. While busy, this block owns one register-file port and the memory data port.

Parameters:
ADDR_W, 12, memory address width; addresses wrap modulo 2^ADDR_W.
DATA_W, 8, register and memory data width.

Ports:
cpu_clk  input  1  clock; all state updates on posedge.
reset  input  1  synchronous, active-high reset.
start  input  1  one-cycle request; sampled only in IDLE.
op  input  2  00 = store (Fx55), 01 = load (Fx65), 10 = BCD (Fx33), 11 = invalid.
x  input  4  highest register index (store/load) or source register (BCD).
i_addr  input  ADDR_W  base address (I register).
busy  output  1  high in every non-IDLE state.
done  output  1  one-cycle pulse on completion.
reg_addr  output  4  register-file address.
reg_writedata  output  DATA_W  register write data.
reg_WE  output  1  register write enable.
reg_readdata  input  DATA_W  register read data; 1-cycle read latency from reg_addr.
mem_addr  output  ADDR_W  memory address.
mem_writedata  output  DATA_W  memory write data.
mem_WE  output  1  memory write enable.
mem_readdata  input  DATA_W  memory read data; 1-cycle read latency from mem_addr.

Behaviour:
- One clock (cpu_clk); reset is synchronous and active-high.
- Reset: state = IDLE; busy, done, reg_WE and mem_WE = 0; reg_addr, reg_writedata, mem_addr and mem_writedata = 0.
- Reset mid-operation returns to IDLE at that edge. No further write strobes are issued and done does not pulse.
- IDLE: if start = 1, latch op, x and i_addr, clear the index counter k, and branch on op. Start is ignored in all other states.
- Store: alternate between two states for k = 0..x.
  - ST_RD: reg_addr = k.
  - ST_WR: mem_addr = I + k, mem_writedata = reg_readdata, mem_WE = 1.
  - After ST_WR, go to DONE if k == x; otherwise k++ and return to ST_RD.
- Load: alternate between two states for k = 0..x.
  - LD_RD: mem_addr = I + k.
  - LD_WR: reg_addr = k, reg_writedata = mem_readdata, reg_WE = 1.
  - Exit after LD_WR with the same k == x rule as store.
- BCD: BC_RD, BC_CALC, BC_WH, BC_WT, BC_WO, then DONE.
  - BC_RD: reg_addr = x.
  - BC_CALC: latch v = reg_readdata. Compute h = v/100, t = (v/10)%10, o = v%10 using constant compare-subtract logic (no divider IP).
  - BC_WH, BC_WT, BC_WO: write h, t and o to I, I+1 and I+2 respectively, mem_WE = 1 in each.
- Invalid op (11): go directly to DONE; no writes.
- DONE: done = 1 for exactly one cycle, busy = 1; next state IDLE.
- Latency, counting start sampled at edge 0 and cycles from that edge:
  - store/load: done in cycle 2(x+1)+1.
  - BCD: done in cycle 6.
  - invalid: done in cycle 1.
- Address arithmetic: I + k is computed in ADDR_W bits with wrap (0xFFF + 1 = 0x000). k is 4 bits, and x = 15 is legal (16 bytes).
- Strobes are asserted only in their named states. reg_WE and mem_WE are never high in the same cycle.
- Unlisted outputs hold 0 in each state.

Optional Feature:
CHIP8_I_INCREMENT_EN
- Defined: adds outputs i_wr (1 bit) and i_next (ADDR_W bits). In the DONE cycle of store or load, i_wr = 1 and i_next = I + x + 1 (wrapped), matching original COSMAC semantics. i_wr is never asserted for BCD or invalid ops.
- Undefined: the ports are absent and I is never modified.

Test Plan:
- Store: V0 = 0x11, V1 = 0x22, V2 = 0x33; start op = 00, x = 2, I = 0x300 -> mem[0x300..0x302] = 11, 22, 33; exactly 3 mem_WE pulses; done in cycle 7; V3 and mem[0x303] untouched.
- Load: mem[0x400] = 0xA5; start op = 01, x = 0, I = 0x400 -> V0 = 0xA5; one reg_WE pulse; done in cycle 3.
- BCD: V7 = 0xFE -> mem[I..I+2] = 2, 5, 4. V7 = 0x00 -> 0, 0, 0. V7 = 0x09 -> 0, 0, 9. Each completes with done in cycle 6.
- Wrap: store x = 3, I = 0xFFE -> writes at 0xFFE, 0xFFF, 0x000, 0x001. With CHIP8_I_INCREMENT_EN, i_next = 0x002.
- Start while busy: second start issued mid-store is ignored; only the first op's writes occur; a single done pulse.
- Reset mid-op: assert reset during the third ST_WR of x = 5 -> IDLE next cycle, busy = 0, no further mem_WE, no done; a new start then runs normally.
